// File: rtl/rs_pkg.sv
// Shared widths and packet types for the age-ordered reservation station.
package rs_pkg;

    localparam int RS_PREG_W    = 6;
    localparam int RS_BMASK_W   = 4;
    localparam int RS_PAYLOAD_W = 16;

    typedef logic [RS_PREG_W-1:0]  PREG_IDX;
    typedef logic [RS_BMASK_W-1:0] B_MASK;

    typedef struct packed {
        PREG_IDX                 src1;
        PREG_IDX                 src2;
        logic                    src1_rdy;
        logic                    src2_rdy;
        B_MASK                   b_mask;
        logic [RS_PAYLOAD_W-1:0] payload;
    } RS_PACKET;

endpackage

// File: rtl/rs_age_select.sv
// Picks the single oldest entry of a candidate vector using the age matrix (one-hot grant).
module rs_age_select #(
    parameter int ENTRIES = 16
) (
    input  logic [ENTRIES-1:0][ENTRIES-1:0] older,
    input  logic [ENTRIES-1:0]              cand,
    output logic [ENTRIES-1:0]              grant
);

    // An entry wins only if it is older than every other live candidate.
    always_comb begin
        grant = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            grant[i] = cand[i];
            for (int j = 0; j < ENTRIES; j++) begin
                if (j != i && cand[j] && !older[i][j]) begin
                    grant[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/rs_age_station.sv
// Multi-dispatch, multi-issue reservation station with CDB wakeup, branch squash/clear
// and oldest-first selection over valid/ready issue ports.
module rs_age_station
    import rs_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int DISP_W  = 3,
    parameter int CDB_W   = 3,
    parameter int ISSUE_W = 2,
    parameter int BMASK_W = RS_BMASK_W,
    parameter int PREG_W  = RS_PREG_W
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [$clog2(DISP_W+1)-1:0]      disp_num,
    input  RS_PACKET [DISP_W-1:0]            disp_pkts,
    output logic [$clog2(DISP_W+1)-1:0]      free_spots,
    output logic [$clog2(ENTRIES+1)-1:0]     occupancy,
    input  logic [CDB_W-1:0]                 cdb_valid,
    input  logic [CDB_W-1:0][PREG_W-1:0]     cdb_tag,
    input  logic [BMASK_W-1:0]               br_resolve,
    input  logic                             br_mispred,
    output logic [ISSUE_W-1:0]               iss_valid,
    input  logic [ISSUE_W-1:0]               iss_ready,
    output RS_PACKET [ISSUE_W-1:0]           iss_pkt
);

    localparam int LANE_W = $clog2(DISP_W+1);
    localparam int OCC_W  = $clog2(ENTRIES+1);

    logic [ENTRIES-1:0]                valid_q, valid_d;
    RS_PACKET [ENTRIES-1:0]            ent_q, ent_d;
    logic [ENTRIES-1:0][ENTRIES-1:0]   older_q, older_d;
    logic [ENTRIES-1:0]                alloc, squash, cand, issued;
    logic [ENTRIES-1:0][LANE_W-1:0]    lane_of;
    logic [ISSUE_W-1:0][ENTRIES-1:0]   port_cand, grant;

    function automatic RS_PACKET update_pkt(RS_PACKET p);
        RS_PACKET q = p;
        for (int j = 0; j < CDB_W; j++) begin
            if (cdb_valid[j] && cdb_tag[j] == p.src1) q.src1_rdy = 1'b1;
            if (cdb_valid[j] && cdb_tag[j] == p.src2) q.src2_rdy = 1'b1;
        end
        if (!br_mispred) q.b_mask = p.b_mask & ~br_resolve;
        return q;
    endfunction

    function automatic logic killed(B_MASK m);
        return br_mispred && ((m & br_resolve) != '0);
    endfunction

    // Lane k lands in the k-th lowest free slot, judged on registered valids only.
    always_comb begin
        int n;
        n       = 0;
        alloc   = '0;
        lane_of = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!valid_q[i] && n < int'(disp_num)) begin
                alloc[i]   = 1'b1;
                lane_of[i] = LANE_W'(n);
                n++;
            end
        end
    end

    always_comb begin
        int cnt;
        cnt = 0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i]) cnt++;
        end
        occupancy  = OCC_W'(cnt);
        free_spots = (ENTRIES - cnt > DISP_W) ? LANE_W'(DISP_W) : LANE_W'(ENTRIES - cnt);
    end

    always_comb begin
        squash = '0;
        cand   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            squash[i] = valid_q[i] && killed(ent_q[i].b_mask);
            cand[i]   = valid_q[i] && ent_q[i].src1_rdy && ent_q[i].src2_rdy && !squash[i];
        end
    end

    // Each port sees the candidates left over after all lower ports took theirs.
    for (genvar p = 0; p < ISSUE_W; p++) begin : g_port
        if (p == 0) begin : g_first
            assign port_cand[p] = cand;
        end else begin : g_rest
            assign port_cand[p] = port_cand[p-1] & ~grant[p-1];
        end
        rs_age_select #(.ENTRIES(ENTRIES)) u_select (
            .older (older_q),
            .cand  (port_cand[p]),
            .grant (grant[p])
        );
    end

    always_comb begin
        RS_PACKET sel;
        iss_valid = '0;
        iss_pkt   = '0;
        issued    = '0;
        for (int p = 0; p < ISSUE_W; p++) begin
            sel          = '0;
            iss_valid[p] = |grant[p];
            for (int i = 0; i < ENTRIES; i++) begin
                if (grant[p][i]) begin
                    sel       = ent_q[i];
                    issued[i] = issued[i] | iss_ready[p];
                end
            end
            sel.b_mask = sel.b_mask & ~br_resolve;
            iss_pkt[p] = sel;
        end
    end

    // New entries are younger than everything stored; same-cycle lanes order by lane index.
    always_comb begin
        valid_d = valid_q;
        ent_d   = ent_q;
        older_d = older_q;
        for (int i = 0; i < ENTRIES; i++) begin
            ent_d[i] = update_pkt(ent_q[i]);
            if (squash[i] || issued[i]) valid_d[i] = 1'b0;
            if (alloc[i]) begin
                ent_d[i]   = update_pkt(disp_pkts[lane_of[i]]);
                valid_d[i] = !killed(disp_pkts[lane_of[i]].b_mask);
            end
            for (int j = 0; j < ENTRIES; j++) begin
                if (alloc[i] && alloc[j]) older_d[i][j] = lane_of[i] < lane_of[j];
                else if (alloc[i])        older_d[i][j] = 1'b0;
                else if (alloc[j])        older_d[i][j] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            ent_q   <= '0;
            older_q <= '0;
        end else begin
            valid_q <= valid_d;
            ent_q   <= ent_d;
            older_q <= older_d;
        end
    end

    a_disp_fits: assert property (@(posedge clock) disable iff (!reset) disp_num <= free_spots);

endmodule

// File: tb/tb_rs_age_station.sv
// Directed self-checking bench for rs_age_station with hand-computed expectations.
module tb_rs_age_station;
    import rs_pkg::*;

    logic             clock = 1'b0;
    logic             reset;
    logic [1:0]       disp_num;
    RS_PACKET [2:0]   disp_pkts;
    logic [1:0]       free_spots;
    logic [4:0]       occupancy;
    logic [2:0]       cdb_valid;
    logic [2:0][5:0]  cdb_tag;
    logic [3:0]       br_resolve;
    logic             br_mispred;
    logic [1:0]       iss_valid;
    logic [1:0]       iss_ready;
    RS_PACKET [1:0]   iss_pkt;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    rs_age_station dut (
        .clock      (clock),
        .reset      (reset),
        .disp_num   (disp_num),
        .disp_pkts  (disp_pkts),
        .free_spots (free_spots),
        .occupancy  (occupancy),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .br_resolve (br_resolve),
        .br_mispred (br_mispred),
        .iss_valid  (iss_valid),
        .iss_ready  (iss_ready),
        .iss_pkt    (iss_pkt)
    );

    function automatic RS_PACKET mkPkt(logic [5:0] s1, logic r1, logic [5:0] s2, logic r2,
                                       logic [3:0] bm, logic [15:0] pl);
        RS_PACKET p;
        p.src1     = s1;
        p.src1_rdy = r1;
        p.src2     = s2;
        p.src2_rdy = r2;
        p.b_mask   = bm;
        p.payload  = pl;
        return p;
    endfunction

    function automatic logic [15:0] drainExp(int n);
        return (n < 14) ? 16'h0D02 + 16'(n) : 16'h0E00 + 16'(n - 14);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge; one-shot inputs drop right after it, outputs settle before returning.
    task automatic applyStimulus();
        @(posedge clock);
        #1;
        disp_num   = '0;
        cdb_valid  = '0;
        br_resolve = '0;
        br_mispred = 1'b0;
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        disp_num   = '0;
        disp_pkts  = '0;
        cdb_valid  = '0;
        cdb_tag    = '0;
        br_resolve = '0;
        br_mispred = 1'b0;
        iss_ready  = '0;
        #12;
        checkOutput("reset_occ", 64'(occupancy), 64'd0);
        checkOutput("reset_free", 64'(free_spots), 64'd3);
        checkOutput("reset_iss_valid", 64'(iss_valid), 64'd0);
        reset = 1'b1;
        @(posedge clock);
        #2;

        // Three ready packets: two issue next cycle, the third one cycle later.
        disp_pkts[0] = mkPkt(6'd1, 1'b1, 6'd2, 1'b1, 4'b0000, 16'h00A0);
        disp_pkts[1] = mkPkt(6'd1, 1'b1, 6'd2, 1'b1, 4'b0000, 16'h00A1);
        disp_pkts[2] = mkPkt(6'd1, 1'b1, 6'd2, 1'b1, 4'b0000, 16'h00A2);
        disp_num     = 2'd3;
        iss_ready    = 2'b11;
        #1;
        checkOutput("t1_no_same_cycle_issue", 64'(iss_valid), 64'd0);
        applyStimulus();
        checkOutput("t1_occ3", 64'(occupancy), 64'd3);
        checkOutput("t1_iss_valid11", 64'(iss_valid), 64'd3);
        checkOutput("t1_port0_lane0", 64'(iss_pkt[0].payload), 64'h00A0);
        checkOutput("t1_port1_lane1", 64'(iss_pkt[1].payload), 64'h00A1);
        applyStimulus();
        checkOutput("t1_occ1", 64'(occupancy), 64'd1);
        checkOutput("t1_iss_valid01", 64'(iss_valid), 64'd1);
        checkOutput("t1_port0_lane2", 64'(iss_pkt[0].payload), 64'h00A2);
        applyStimulus();
        checkOutput("t1_occ0", 64'(occupancy), 64'd0);
        checkOutput("t1_iss_valid00", 64'(iss_valid), 64'd0);

        // Wakeup of stored entry, then insert bypass of a dispatching one.
        disp_pkts[0] = mkPkt(6'd12, 1'b0, 6'd5, 1'b1, 4'b0000, 16'h00B0);
        disp_num     = 2'd1;
        applyStimulus();
        cdb_valid  = 3'b010;
        cdb_tag[1] = 6'd12;
        #1;
        checkOutput("t2_wake_not_same_cycle", 64'(iss_valid), 64'd0);
        applyStimulus();
        checkOutput("t2_woken_valid", 64'(iss_valid), 64'd1);
        checkOutput("t2_woken_payload", 64'(iss_pkt[0].payload), 64'h00B0);
        checkOutput("t2_woken_rdy", 64'(iss_pkt[0].src1_rdy), 64'd1);
        applyStimulus();
        checkOutput("t2_drained", 64'(occupancy), 64'd0);
        disp_pkts[0] = mkPkt(6'd7, 1'b0, 6'd8, 1'b1, 4'b0000, 16'h00C0);
        disp_num     = 2'd1;
        cdb_valid    = 3'b100;
        cdb_tag[2]   = 6'd7;
        applyStimulus();
        checkOutput("t2_bypass_valid", 64'(iss_valid), 64'd1);
        checkOutput("t2_bypass_payload", 64'(iss_pkt[0].payload), 64'h00C0);
        applyStimulus();
        checkOutput("t2_bypass_drained", 64'(occupancy), 64'd0);

        // Fill all 16 entries, then free two and confirm reused slots are youngest.
        iss_ready = 2'b00;
        for (int k = 0; k < 5; k++) begin
            for (int l = 0; l < 3; l++) begin
                disp_pkts[l] = mkPkt(6'd1, 1'b1, 6'd2, 1'b1, 4'b0000, 16'h0D00 + 16'(3 * k + l));
            end
            disp_num = 2'd3;
            applyStimulus();
        end
        checkOutput("t3_occ15", 64'(occupancy), 64'd15);
        checkOutput("t3_free1", 64'(free_spots), 64'd1);
        disp_pkts[0] = mkPkt(6'd1, 1'b1, 6'd2, 1'b1, 4'b0000, 16'h0D0F);
        disp_num     = 2'd1;
        applyStimulus();
        checkOutput("t3_occ16", 64'(occupancy), 64'd16);
        checkOutput("t3_free0", 64'(free_spots), 64'd0);
        checkOutput("t3_iss_valid11", 64'(iss_valid), 64'd3);
        checkOutput("t3_port0_oldest", 64'(iss_pkt[0].payload), 64'h0D00);
        checkOutput("t3_port1_next", 64'(iss_pkt[1].payload), 64'h0D01);
        iss_ready = 2'b11;
        #1;
        checkOutput("t3_free_not_same_cycle", 64'(free_spots), 64'd0);
        applyStimulus();
        iss_ready = 2'b00;
        #1;
        checkOutput("t3_free2", 64'(free_spots), 64'd2);
        checkOutput("t3_occ14", 64'(occupancy), 64'd14);
        checkOutput("t3_port0_after", 64'(iss_pkt[0].payload), 64'h0D02);
        disp_pkts[0] = mkPkt(6'd1, 1'b1, 6'd2, 1'b1, 4'b0000, 16'h0E00);
        disp_pkts[1] = mkPkt(6'd1, 1'b1, 6'd2, 1'b1, 4'b0000, 16'h0E01);
        disp_num     = 2'd2;
        applyStimulus();
        checkOutput("t3_reused_slot_younger", 64'(iss_pkt[0].payload), 64'h0D02);
        iss_ready = 2'b11;
        for (int c = 0; c < 8; c++) begin
            checkOutput($sformatf("t3_drain_p0_%0d", c), 64'(iss_pkt[0].payload), 64'(drainExp(2 * c)));
            checkOutput($sformatf("t3_drain_p1_%0d", c), 64'(iss_pkt[1].payload), 64'(drainExp(2 * c + 1)));
            applyStimulus();
        end
        checkOutput("t3_drained", 64'(occupancy), 64'd0);

        // Mispredict kills A before it is ever offered; B keeps its own mask.
        iss_ready    = 2'b00;
        disp_pkts[0] = mkPkt(6'd1, 1'b1, 6'd2, 1'b1, 4'b0010, 16'h00A5);
        disp_pkts[1] = mkPkt(6'd20, 1'b0, 6'd2, 1'b1, 4'b0001, 16'h00B5);
        disp_num     = 2'd2;
        applyStimulus();
        br_resolve = 4'b0010;
        br_mispred = 1'b1;
        iss_ready  = 2'b11;
        #1;
        checkOutput("t4_squashed_not_offered", 64'(iss_valid), 64'd0);
        applyStimulus();
        checkOutput("t4_occ1", 64'(occupancy), 64'd1);
        checkOutput("t4_none_offered", 64'(iss_valid), 64'd0);
        cdb_valid  = 3'b001;
        cdb_tag[0] = 6'd20;
        applyStimulus();
        checkOutput("t4_b_offered", 64'(iss_valid), 64'd1);
        checkOutput("t4_b_payload", 64'(iss_pkt[0].payload), 64'h00B5);
        checkOutput("t4_b_mask_kept", 64'(iss_pkt[0].b_mask), 64'b0001);
        applyStimulus();
        checkOutput("t4_drained", 64'(occupancy), 64'd0);
        disp_pkts[0] = mkPkt(6'd1, 1'b1, 6'd2, 1'b1, 4'b0100, 16'h00C5);
        disp_num     = 2'd1;
        br_resolve   = 4'b0100;
        br_mispred   = 1'b1;
        applyStimulus();
        checkOutput("t4_disp_squash_occ", 64'(occupancy), 64'd0);
        checkOutput("t4_disp_squash_valid", 64'(iss_valid), 64'd0);

        // Correct prediction clears the mask bit, visible on the issue port the same cycle.
        iss_ready    = 2'b00;
        disp_pkts[0] = mkPkt(6'd1, 1'b1, 6'd2, 1'b1, 4'b0010, 16'h00A6);
        disp_pkts[1] = mkPkt(6'd1, 1'b1, 6'd2, 1'b1, 4'b0001, 16'h00B6);
        disp_num     = 2'd2;
        applyStimulus();
        br_resolve = 4'b0010;
        br_mispred = 1'b0;
        #1;
        checkOutput("t5_iss_valid11", 64'(iss_valid), 64'd3);
        checkOutput("t5_a_payload", 64'(iss_pkt[0].payload), 64'h00A6);
        checkOutput("t5_a_mask_comb", 64'(iss_pkt[0].b_mask), 64'b0000);
        checkOutput("t5_b_mask_comb", 64'(iss_pkt[1].b_mask), 64'b0001);
        applyStimulus();
        checkOutput("t5_occ2", 64'(occupancy), 64'd2);
        checkOutput("t5_a_mask_stored", 64'(iss_pkt[0].b_mask), 64'b0000);
        iss_ready = 2'b11;
        applyStimulus();
        checkOutput("t5_drained", 64'(occupancy), 64'd0);

        // Back-pressure on port 0 holds the oldest entry ahead of younger ready ones.
        iss_ready    = 2'b00;
        disp_pkts[0] = mkPkt(6'd1, 1'b1, 6'd2, 1'b1, 4'b0000, 16'h00F0);
        disp_num     = 2'd1;
        applyStimulus();
        for (int h = 0; h < 3; h++) begin
            if (h == 0) begin
                disp_pkts[0] = mkPkt(6'd1, 1'b1, 6'd2, 1'b1, 4'b0000, 16'h00F1);
                disp_pkts[1] = mkPkt(6'd1, 1'b1, 6'd2, 1'b1, 4'b0000, 16'h00F2);
                disp_num     = 2'd2;
            end
            #1;
            checkOutput($sformatf("t6_hold_valid_%0d", h), 64'(iss_valid[0]), 64'd1);
            checkOutput($sformatf("t6_hold_payload_%0d", h), 64'(iss_pkt[0].payload), 64'h00F0);
            applyStimulus();
        end
        checkOutput("t6_occ3", 64'(occupancy), 64'd3);
        checkOutput("t6_port1_y", 64'(iss_pkt[1].payload), 64'h00F1);
        iss_ready = 2'b10;
        applyStimulus();
        iss_ready = 2'b00;
        #1;
        checkOutput("t6_occ2", 64'(occupancy), 64'd2);
        checkOutput("t6_port0_x", 64'(iss_pkt[0].payload), 64'h00F0);
        checkOutput("t6_port1_z", 64'(iss_pkt[1].payload), 64'h00F2);
        reset = 1'b0;
        #1;
        checkOutput("t6_midreset_valid", 64'(iss_valid), 64'd0);
        checkOutput("t6_midreset_occ", 64'(occupancy), 64'd0);
        checkOutput("t6_midreset_free", 64'(free_spots), 64'd3);
        reset = 1'b1;
        applyStimulus();
        checkOutput("t6_after_reset_occ", 64'(occupancy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
